// File: rtl/entrada_rpn.sv
// RPN front-end: key sync, debounce, press pulses and the step counter.
// RPN_DEBOUNCE_EN builds the debounce counters; without it keys pass straight.
module entrada_rpn #(
  parameter int DEBOUNCE_CICLOS = 500000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KeyEnter_n,
  input  logic       KeyReset_n,
  input  logic       Enable,
  output logic       Enter,
  output logic       Reset_borda,
  output logic [1:0] Contagem
);

  if (DEBOUNCE_CICLOS < 2) begin : g_bad_cfg
    $error("entrada_rpn: DEBOUNCE_CICLOS must be >= 2");
  end

  // bit 0 = Enter channel, bit 1 = Reset-button channel
  logic [1:0] key_n;
  logic [1:0] sync1_q;
  logic [1:0] est_q;
  logic [1:0] est_d;
  logic [1:0] prev_q;
  logic [1:0] pulse_q;
  logic [1:0] pulse_d;
  logic [1:0] cont_q;
  logic [1:0] cont_d;

  assign key_n = {KeyReset_n, KeyEnter_n};

`ifdef RPN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] LIM = CW'(DEBOUNCE_CICLOS - 1);

  logic [1:0]    sync2_q;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      est_d[i] = est_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != est_q[i]) begin
        if (cnt_q[i] == LIM) begin
          est_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync2_q  <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync2_q  <= sync1_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end
`else
  // est_q doubles as the second synchroniser stage here
  assign est_d = sync1_q;
`endif

  assign pulse_d = prev_q & ~est_q;

  always_comb begin
    cont_d = cont_q;
    if (Enable) begin
      cont_d = pulse_q[1] ? 2'b00 : cont_q + 2'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q <= 2'b11;
      est_q   <= 2'b11;
      prev_q  <= 2'b11;
      pulse_q <= 2'b00;
      cont_q  <= 2'b00;
    end else begin
      sync1_q <= key_n;
      est_q   <= est_d;
      prev_q  <= est_q;
      pulse_q <= pulse_d;
      cont_q  <= cont_d;
    end
  end

  assign Enter       = pulse_q[0];
  assign Reset_borda = pulse_q[1];
  assign Contagem    = cont_q;

endmodule

// File: tb/tb_entrada_rpn.sv
// Directed bench for entrada_rpn; expectations follow RPN_DEBOUNCE_EN.
module tb_entrada_rpn;

  localparam int D = 4;
`ifdef RPN_DEBOUNCE_EN
  localparam int LAT = D + 3;
  localparam bit DEB = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DEB = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic       KeyEnter_n;
  logic       KeyReset_n;
  logic       Enable;
  logic       en_loop;
  logic       en_force;
  logic       Enter;
  logic       Reset_borda;
  logic [1:0] Contagem;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  assign Enable = en_loop ? (Enter | Reset_borda) : en_force;

  entrada_rpn #(.DEBOUNCE_CICLOS(D)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .KeyEnter_n (KeyEnter_n),
    .KeyReset_n (KeyReset_n),
    .Enable     (Enable),
    .Enter      (Enter),
    .Reset_borda(Reset_borda),
    .Contagem   (Contagem)
  );

  task automatic apply_reset();
    @(negedge Clock);
    Reset = 1'b1;
    KeyEnter_n = 1'b1;
    KeyReset_n = 1'b1;
    en_loop = 1'b1;
    en_force = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic press(input bit ke, input bit kr, input int hold,
                       output int fe, output int fr,
                       output int ne, output int nr,
                       output logic [1:0] c_at, output logic [1:0] c_nx);
    fe = -1; fr = -1; ne = 0; nr = 0;
    c_at = 2'bxx; c_nx = 2'bxx;
    @(negedge Clock);
    if (ke) KeyEnter_n = 1'b0;
    if (kr) KeyReset_n = 1'b0;
    for (int k = 1; k <= hold; k++) begin
      @(negedge Clock);
      if (Enter) begin
        ne++;
        if (fe < 0) fe = k;
      end
      if (Reset_borda) begin
        nr++;
        if (fr < 0) fr = k;
      end
      if (k == LAT) c_at = Contagem;
      if (k == LAT + 1) c_nx = Contagem;
    end
    KeyEnter_n = 1'b1;
    KeyReset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      if (Enter) ne++;
      if (Reset_borda) nr++;
    end
  endtask

  task automatic test_reset_press();
    int fe, fr, ne, nr;
    logic [1:0] ca, cn;
    apply_reset();
    checks++;
    if (Enter !== 1'b0) begin
      errors++; $display("FAIL reset_enter got %b want 0", Enter);
    end
    checks++;
    if (Reset_borda !== 1'b0) begin
      errors++; $display("FAIL reset_rb got %b want 0", Reset_borda);
    end
    checks++;
    if (Contagem !== 2'b00) begin
      errors++; $display("FAIL reset_cont got %b want 00", Contagem);
    end
    press(1'b1, 1'b0, 20, fe, fr, ne, nr, ca, cn);
    checks++;
    if (fe !== LAT) begin
      errors++; $display("FAIL press_latency got %0d want %0d", fe, LAT);
    end
    checks++;
    if (ne !== 1) begin
      errors++; $display("FAIL press_count got %0d want 1", ne);
    end
    checks++;
    if (nr !== 0) begin
      errors++; $display("FAIL press_rb_count got %0d want 0", nr);
    end
    checks++;
    if (ca !== 2'b00) begin
      errors++; $display("FAIL press_cont_at got %b want 00", ca);
    end
    checks++;
    if (cn !== 2'b01) begin
      errors++; $display("FAIL press_cont_next got %b want 01", cn);
    end
  endtask

  task automatic test_bounce();
    int n = 0;
    int exp_n;
    logic [1:0] exp_c;
    exp_n = DEB ? 0 : 5;
    exp_c = 2'(1 + exp_n);
    for (int t = 0; t < 20; t++) begin
      @(negedge Clock);
      if (Enter) n++;
      KeyEnter_n = t[1];
    end
    KeyEnter_n = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge Clock);
      if (Enter) n++;
    end
    checks++;
    if (n !== exp_n) begin
      errors++; $display("FAIL bounce_pulses got %0d want %0d", n, exp_n);
    end
    checks++;
    if (Contagem !== exp_c) begin
      errors++; $display("FAIL bounce_cont got %b want %b", Contagem, exp_c);
    end
  endtask

  task automatic test_full_cycle();
    int fe, fr, ne, nr;
    logic [1:0] ca, cn;
    logic [1:0] exp_c;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, 20, fe, fr, ne, nr, ca, cn);
      exp_c = 2'(i + 1);
      checks++;
      if (ne !== 1) begin
        errors++; $display("FAIL cycle_pulses[%0d] got %0d want 1", i, ne);
      end
      checks++;
      if (Contagem !== exp_c) begin
        errors++;
        $display("FAIL cycle_cont[%0d] got %b want %b", i, Contagem, exp_c);
      end
    end
  endtask

  task automatic test_reset_priority();
    int fe, fr, ne, nr;
    logic [1:0] ca, cn;
    apply_reset();
    press(1'b1, 1'b0, 20, fe, fr, ne, nr, ca, cn);
    press(1'b1, 1'b0, 20, fe, fr, ne, nr, ca, cn);
    press(1'b0, 1'b1, 20, fe, fr, ne, nr, ca, cn);
    checks++;
    if (fr !== LAT) begin
      errors++; $display("FAIL rb_latency got %0d want %0d", fr, LAT);
    end
    checks++;
    if (nr !== 1 || ne !== 0) begin
      errors++; $display("FAIL rb_counts got rb=%0d en=%0d want 1/0", nr, ne);
    end
    checks++;
    if (ca !== 2'b10) begin
      errors++; $display("FAIL rb_cont_at got %b want 10", ca);
    end
    checks++;
    if (cn !== 2'b00) begin
      errors++; $display("FAIL rb_cont_next got %b want 00", cn);
    end
    press(1'b1, 1'b0, 20, fe, fr, ne, nr, ca, cn);
    press(1'b1, 1'b1, 20, fe, fr, ne, nr, ca, cn);
    checks++;
    if (fe !== LAT || fr !== LAT) begin
      errors++; $display("FAIL both_latency got en=%0d rb=%0d want %0d", fe, fr, LAT);
    end
    checks++;
    if (ne !== 1 || nr !== 1) begin
      errors++; $display("FAIL both_counts got en=%0d rb=%0d want 1/1", ne, nr);
    end
    checks++;
    if (ca !== 2'b01 || Contagem !== 2'b00) begin
      errors++; $display("FAIL both_cont got at=%b end=%b want 01/00", ca, Contagem);
    end
  endtask

  task automatic test_reset_mid();
    int n_pre = 0;
    int n_rst = 0;
    int n_post = 0;
    int first = -1;
    int rst_at;
    rst_at = DEB ? 4 : 2;
    apply_reset();
    @(negedge Clock);
    KeyEnter_n = 1'b0;
    for (int k = 1; k <= rst_at; k++) begin
      @(negedge Clock);
      if (Enter) n_pre++;
    end
    Reset = 1'b1;
    repeat (2) begin
      @(negedge Clock);
      if (Enter) n_rst++;
    end
    Reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clock);
      if (Enter) begin
        n_post++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (n_pre !== 0 || n_rst !== 0) begin
      errors++; $display("FAIL mid_early got pre=%0d rst=%0d want 0/0", n_pre, n_rst);
    end
    checks++;
    if (first !== LAT || n_post !== 1) begin
      errors++; $display("FAIL mid_after got at=%0d n=%0d want %0d/1", first, n_post, LAT);
    end
    checks++;
    if (Contagem !== 2'b01) begin
      errors++; $display("FAIL mid_cont got %b want 01", Contagem);
    end
    KeyEnter_n = 1'b1;
    repeat (20) @(negedge Clock);
    KeyEnter_n = 1'b0;
    repeat (LAT) @(negedge Clock);
    checks++;
    if (Enter !== 1'b1) begin
      errors++; $display("FAIL samecyc_pulse got %b want 1", Enter);
    end
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (Enter !== 1'b0 || Contagem !== 2'b00) begin
      errors++; $display("FAIL samecyc_reset got en=%b cont=%b want 0/00", Enter, Contagem);
    end
    Reset = 1'b0;
    KeyEnter_n = 1'b1;
    repeat (20) @(negedge Clock);
  endtask

  task automatic test_enable_misuse();
    @(negedge Clock);
    en_loop = 1'b0;
    en_force = 1'b1;
    repeat (3) @(negedge Clock);
    en_force = 1'b0;
    en_loop = 1'b1;
    checks++;
    if (Contagem !== 2'b11) begin
      errors++; $display("FAIL misuse_cont got %b want 11", Contagem);
    end
  endtask

  task automatic test_glitch();
    int n = 0;
    int first = -1;
    int exp_n;
    int exp_f;
    logic [1:0] exp_c;
    exp_n = DEB ? 0 : 1;
    exp_f = DEB ? -1 : LAT;
    exp_c = DEB ? 2'b00 : 2'b01;
    apply_reset();
    @(negedge Clock);
    KeyEnter_n = 1'b0;
    @(negedge Clock);
    if (Enter) begin n++; first = 1; end
    KeyEnter_n = 1'b1;
    for (int k = 2; k <= 21; k++) begin
      @(negedge Clock);
      if (Enter) begin
        n++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (n !== exp_n || first !== exp_f) begin
      errors++; $display("FAIL glitch got n=%0d at=%0d want %0d/%0d", n, first, exp_n, exp_f);
    end
    checks++;
    if (Contagem !== exp_c) begin
      errors++; $display("FAIL glitch_cont got %b want %b", Contagem, exp_c);
    end
  endtask

  initial begin
    Reset = 1'b1;
    KeyEnter_n = 1'b1;
    KeyReset_n = 1'b1;
    en_loop = 1'b1;
    en_force = 1'b0;
    test_reset_press();
    test_bounce();
    test_full_cycle();
    test_reset_priority();
    test_reset_mid();
    apply_reset();
    test_enable_misuse();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/entrada_rpn.md
# entrada_rpn

Input front-end of the RPN 8-bit ALU control path, sitting directly upstream of the RPN control decoder. It synchronises and debounces the two raw push-buttons (Enter, Reset), turns each press into a single-cycle pulse, and holds the 2-bit step counter `Contagem` that the decoder turns into LoadA/LoadB/LoadCarry/LoadOp/Resultado. The counter advances on the decoder's `Enable` return signal.

## Interface
- `DEBOUNCE_CICLOS`, default 500000: consecutive cycles a new button level must hold before it is accepted (10 ms at 50 MHz); legal range ≥ 2.
- `Clock` input 1: single system clock; all state changes on its rising edge.
- `Reset` input 1: synchronous, active-high system reset.
- `KeyEnter_n` input 1: raw Enter button, active-low, asynchronous to `Clock`, bouncy.
- `KeyReset_n` input 1: raw RPN-reset button, active-low, asynchronous, bouncy.
- `Enable` input 1: counter advance request returned by the decoder (Enter OR Reset_borda).
- `Enter` output 1: one-cycle pulse per accepted Enter press.
- `Reset_borda` output 1: one-cycle pulse per accepted Reset-button press.
- `Contagem` output 2: current RPN step: 00 = A, 01 = B, 10 = Carry/Op, 11 = Resultado.

## Operation
- Each button has its own identical channel:
  - 2-flop synchroniser.
  - Debounce counter of width $clog2(DEBOUNCE_CICLOS+1).
  - Registered stable level (`estavel`, active-low sense).
  - Registered edge detector.
- Debounce, per cycle:
  - If the synchronised level equals `estavel`, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CICLOS−1 while still differing, `estavel` takes the synchronised level and the counter clears.
  - A bounce back to the old level before that point clears the counter, and no change is accepted.
- Pulse generation: the output pulse is registered and is high for exactly one cycle after `estavel` goes 1→0 (press). Release (0→1) produces no pulse. Holding the button never repeats the pulse.
- Step counter `Contagem`, priority order:
  1. `Reset` → 00.
  2. `Enable` and `Reset_borda` → 00.
  3. `Enable` → `Contagem`+1, wrapping 11→00.
  4. Otherwise hold.
- `Contagem` updates on the edge that ends the pulse. The decoder therefore decodes the pulse against the pre-increment step.
- `Enter` and `Reset_borda` in the same cycle: both pulses are asserted (the decoder masks all loads), and `Contagem` → 00.
- `Enable` high with neither pulse (external misuse): `Contagem` still increments. This is required behaviour, not an error.

## Timing
- Reset values:
  - `Enter` = 0, `Reset_borda` = 0, `Contagem` = 00.
  - Synchronisers and `estavel` = 1 (released).
  - Debounce counters = 0.
- Press latency: from the first rising edge that samples the new raw level, the pulse is high on edge DEBOUNCE_CICLOS+3, provided the level is held clean. The 3 cycles are 2 synchroniser stages plus 1 edge register.
- Pulse width: exactly 1 cycle. Minimum press-to-press spacing equals the debounce of the press plus the debounce of the release.
- `Contagem` changes 1 cycle after the pulse rises.
- `Reset` asserted mid-debounce:
  - All channel state returns to released and no pending pulse is emitted.
  - A button still held when `Reset` deasserts is seen as a new press and pulses DEBOUNCE_CICLOS+3 cycles later.
- `Reset` asserted in the same cycle as a pulse: the outputs read 0 the next cycle, and `Contagem` = 00.

## Configuration
- `RPN_DEBOUNCE_EN` defined: the debounce counters are built as described.
- Not defined:
  - `estavel` loads the synchroniser output directly every cycle, and no counter is synthesised.
  - Press latency becomes 3 cycles, and `DEBOUNCE_CICLOS` is ignored.
  - Intended for fast simulation and for boards with hardware-debounced keys.
  - Pulse, counter and reset behaviour is otherwise identical.

## Test plan
- Reset and press: `DEBOUNCE_CICLOS`=4, macro defined; `Reset` 2 cycles, then `KeyEnter_n`=0 held 20 cycles → `Enter` high exactly once, 7 cycles after the sampled fall; `Contagem` 00→01 the following cycle.
- Bounce rejection: `KeyEnter_n` toggles 0/1 every 2 cycles for 20 cycles, then stays 1 → no `Enter` pulse, `Contagem` unchanged.
- Full cycle and wrap: four clean Enter presses, with `Enable` driven as `Enter`|`Reset_borda` → `Contagem` 01, 10, 11, 00; one pulse per press.
- Reset-button priority: `Contagem`=10, then press `KeyReset_n` → `Reset_borda` 1 cycle, then `Contagem`=00. Both keys pressed on the same edge → both pulses in the same cycle, `Contagem`=00.
- Reset mid-operation: assert `Reset` at debounce count 2 with `KeyEnter_n` held low → no pulse during reset; after release, one pulse 7 cycles later and `Contagem` = 01.
- Macro undefined: clean press → `Enter` pulse 3 cycles after the sampled fall; a 1-cycle glitch low (≥1 sampled cycle) also produces a pulse.
